// File: rtl/rx_arbiter_to_tcp_if.sv
// Bundle of the receiver-FIFO side, the SiTCP transmit side and the buffer status
// of rx_arbiter_to_tcp. "master" is the merger itself, "slave" is its environment.
interface rx_arbiter_to_tcp_if #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 256
);
    // Handshakes: a receiver word moves when FE_FIFO_EMPTY[i]=0 and FE_FIFO_READ[i]=1 at
    // the same rising edge (first-word-fall-through, read acts as ready); a byte moves
    // when TCP_TX_WR=1, which is only raised while TCP_TX_FULL=0.
    logic [CHANNELS-1:0]      CH_ENABLE;
    logic [CHANNELS-1:0]      FE_FIFO_EMPTY;
    logic [32*CHANNELS-1:0]   FE_FIFO_DATA;
    logic [CHANNELS-1:0]      FE_FIFO_READ;
    logic                     TCP_TX_FULL;
    logic                     TCP_TX_WR;
    logic [7:0]               TCP_TX_DATA;
    logic                     FIFO_EMPTY;
    logic                     FIFO_FULL;
    logic [$clog2(DEPTH):0]   WORD_COUNT;

    modport master (
        input  CH_ENABLE, FE_FIFO_EMPTY, FE_FIFO_DATA, TCP_TX_FULL,
        output FE_FIFO_READ, TCP_TX_WR, TCP_TX_DATA, FIFO_EMPTY, FIFO_FULL, WORD_COUNT
    );

    modport slave (
        output CH_ENABLE, FE_FIFO_EMPTY, FE_FIFO_DATA, TCP_TX_FULL,
        input  FE_FIFO_READ, TCP_TX_WR, TCP_TX_DATA, FIFO_EMPTY, FIFO_FULL, WORD_COUNT
    );
endinterface

// File: rtl/rx_arbiter_to_tcp.sv
// Round-robin merge of CHANNELS 32-bit receiver FIFOs into a DEPTH-word buffer,
// drained as a byte stream into the SiTCP transmit port.
module rx_arbiter_to_tcp #(
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 256,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    rx_arbiter_to_tcp_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [AW-1:0]       wr_addr_q, rd_addr_q;
    logic [AW:0]         count_q, count_d;
    logic [1:0]          bidx_q;
    logic [31:0]         mem_q [DEPTH];

    logic [CHANNELS-1:0] req;
    logic [PW-1:0]       sel;
    logic                found;
    logic [31:0]         sel_data;
    logic [31:0]         head;
    logic [1:0]          lane;
    logic [7:0]          tx_byte;
    logic                fifo_empty, fifo_full;
    logic                pop, tx_wr, retire;

    assign req = bus.CH_ENABLE & ~bus.FE_FIFO_EMPTY;

    // First requester at or after the pointer, wrapping at CHANNELS.
    always_comb begin : rr_select
        logic [PW:0] cand;
        cand  = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(CHANNELS)) begin
                cand = cand - (PW+1)'(CHANNELS);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == PW'(i)) begin
                sel_data = bus.FE_FIFO_DATA[32*i +: 32];
            end
        end
    end

    // The full check uses the registered count, so a same-cycle retire does not free a slot.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign pop        = found && !fifo_full && !BUS_RST;
    assign tx_wr      = !BUS_RST && !bus.TCP_TX_FULL && !fifo_empty;
    assign retire     = tx_wr && (bidx_q == 2'd3);

    always_comb begin : ptr_next
        logic [PW:0] nxt;
        nxt   = {1'b0, sel} + (PW+1)'(1);
        ptr_d = ptr_q;
        if (pop) begin
            ptr_d = (nxt == (PW+1)'(CHANNELS)) ? '0 : nxt[PW-1:0];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({pop, retire})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    assign head = mem_q[rd_addr_q];
    assign lane = MSB_FIRST ? (2'd3 - bidx_q) : bidx_q;

    always_comb begin
        tx_byte = head[7:0];
        case (lane)
            2'd0:    tx_byte = head[7:0];
            2'd1:    tx_byte = head[15:8];
            2'd2:    tx_byte = head[23:16];
            default: tx_byte = head[31:24];
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            ptr_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            count_q   <= '0;
            bidx_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (pop) begin
                wr_addr_q <= wr_addr_q + AW'(1);
            end
            if (retire) begin
                rd_addr_q <= rd_addr_q + AW'(1);
            end
            if (tx_wr) begin
                bidx_q <= bidx_q + 2'd1;
            end
        end
    end

    // Storage is not reset; validity is tracked by the count alone.
    always_ff @(posedge BUS_CLK) begin
        if (pop) begin
            mem_q[wr_addr_q] <= sel_data;
        end
    end

    assign bus.FE_FIFO_READ = pop ? (CHANNELS'(1) << sel) : '0;
    assign bus.TCP_TX_WR    = tx_wr;
    assign bus.TCP_TX_DATA  = tx_byte;
    assign bus.FIFO_EMPTY   = fifo_empty;
    assign bus.FIFO_FULL    = fifo_full;
    assign bus.WORD_COUNT   = count_q;
endmodule

// File: tb/tb_rx_arbiter_to_tcp.sv
// Bench for rx_arbiter_to_tcp: two instances (LSB-first and MSB-first) share one
// stimulus and are compared every cycle against a queue-based word/byte model.
module tb_rx_arbiter_to_tcp;
    localparam int CH    = 4;
    localparam int DEPTH = 4;
    localparam int CAP   = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] en;
    logic [CH-1:0] fe_empty;
    logic [32*CH-1:0] fe_data;
    logic          tx_full;

    always #5 clk = ~clk;

    rx_arbiter_to_tcp_if #(.CHANNELS(CH), .DEPTH(DEPTH)) bl ();
    rx_arbiter_to_tcp_if #(.CHANNELS(CH), .DEPTH(DEPTH)) bm ();

    assign bl.CH_ENABLE     = en;
    assign bl.FE_FIFO_EMPTY = fe_empty;
    assign bl.FE_FIFO_DATA  = fe_data;
    assign bl.TCP_TX_FULL   = tx_full;
    assign bm.CH_ENABLE     = en;
    assign bm.FE_FIFO_EMPTY = fe_empty;
    assign bm.FE_FIFO_DATA  = fe_data;
    assign bm.TCP_TX_FULL   = tx_full;

    rx_arbiter_to_tcp #(.CHANNELS(CH), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
        .BUS_CLK(clk), .BUS_RST(rst), .bus(bl.master)
    );
    rx_arbiter_to_tcp #(.CHANNELS(CH), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
        .BUS_CLK(clk), .BUS_RST(rst), .bus(bm.master)
    );

    // Receiver FIFO contents, one array per channel with head/tail indices.
    logic [31:0] ch_mem [CH][CAP];
    int          ch_head [CH];
    int          ch_tail [CH];

    // Model: words held by the merger in pop order, bytes already sent of the head word,
    // and the channel that gets first look at the next pop.
    logic [31:0] exp_q[$];
    int          nb;
    int          rr;
    logic [7:0]  got_l[$];
    logic [7:0]  got_m[$];
    int          n_chk;
    int          n_err;
    bit          do_chk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_ch();
        for (int i = 0; i < CH; i++) begin
            ch_head[i] = 0;
            ch_tail[i] = 0;
        end
    endtask

    task automatic push_word(input int c, input logic [31:0] w);
        if (ch_tail[c] < CAP) begin
            ch_mem[c][ch_tail[c]] = w;
            ch_tail[c]++;
        end
    endtask

    task automatic drive_fe();
        for (int i = 0; i < CH; i++) begin
            fe_empty[i] = (ch_tail[i] == ch_head[i]);
            fe_data[32*i +: 32] = fe_empty[i] ? 32'h0 : ch_mem[i][ch_head[i]];
        end
    endtask

    // One clock: predict at the falling edge, compare, then advance the model at the rising edge.
    task automatic cycle();
        logic [CH-1:0] req;
        logic [CH-1:0] exp_rd;
        logic [31:0]   hw;
        logic          pop;
        logic          wr;
        logic          found;
        int            sel;
        int            c;
        drive_fe();
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            req[i] = en[i] && (ch_tail[i] > ch_head[i]);
        end
        pop   = (req != '0) && (exp_q.size() < DEPTH) && !rst;
        sel   = 0;
        found = 1'b0;
        for (int k = 0; k < CH; k++) begin
            c = (rr + k) % CH;
            if (!found && req[c]) begin
                found = 1'b1;
                sel   = c;
            end
        end
        exp_rd = pop ? CH'(1 << sel) : '0;
        wr     = !rst && !tx_full && (exp_q.size() > 0);
        hw     = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
        if (bl.TCP_TX_WR) got_l.push_back(bl.TCP_TX_DATA);
        if (bm.TCP_TX_WR) got_m.push_back(bm.TCP_TX_DATA);
        if (do_chk) begin
            check("read_lsb", bl.FE_FIFO_READ, exp_rd);
            check("read_msb", bm.FE_FIFO_READ, exp_rd);
            check("wr_lsb", bl.TCP_TX_WR, wr);
            check("wr_msb", bm.TCP_TX_WR, wr);
            check("empty", bl.FIFO_EMPTY, exp_q.size() == 0);
            check("full", bl.FIFO_FULL, exp_q.size() == DEPTH);
            check("count_lsb", bl.WORD_COUNT, exp_q.size());
            check("count_msb", bm.WORD_COUNT, exp_q.size());
            if (wr) begin
                check("byte_lsb", bl.TCP_TX_DATA, hw[8*nb +: 8]);
                check("byte_msb", bm.TCP_TX_DATA, hw[31-8*nb -: 8]);
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            nb = 0;
            rr = 0;
        end else begin
            if (wr) begin
                nb++;
                if (nb == 4) begin
                    nb = 0;
                    void'(exp_q.pop_front());
                end
            end
            if (pop) begin
                exp_q.push_back(ch_mem[sel][ch_head[sel]]);
                ch_head[sel]++;
                rr = (sel + 1) % CH;
            end
        end
        #1;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        n_chk = 0; n_err = 0; nb = 0; rr = 0;
        do_chk = 1'b0;
        en = '0; tx_full = 1'b0; rst = 1'b1;
        clear_ch();
        cycle();
        do_chk = 1'b1;

        // Reset held with every channel requesting.
        en = 4'hf;
        for (int i = 0; i < CH; i++) push_word(i, 32'hA0A0_0000 + 32'(i));
        repeat (3) cycle();
        check("rst_count", bl.WORD_COUNT, 0);
        clear_ch();
        rst = 1'b0;

        // Single word on channel 1.
        got_l.delete(); got_m.delete();
        push_word(1, 32'h1122_3344);
        repeat (7) cycle();
        check("single_nbytes", got_l.size(), 4);
        if (got_l.size() == 4 && got_m.size() == 4) begin
            check("single_l0", got_l[0], 8'h44);
            check("single_l3", got_l[3], 8'h11);
            check("single_m0", got_m[0], 8'h11);
            check("single_m3", got_m[3], 8'h44);
        end
        check("single_empty", bl.FIFO_EMPTY, 1);

        // Fairness with all channels busy, then channel 2 masked off.
        reset_cycle();
        clear_ch();
        for (int k = 0; k < 40; k++)
            for (int i = 0; i < CH; i++) push_word(i, (32'(i) << 24) | 32'(k));
        en = 4'hf;
        repeat (40) cycle();
        en = 4'b1011;
        repeat (40) cycle();
        en = '0;
        repeat (20) cycle();
        check("fair_drained", bl.FIFO_EMPTY, 1);

        // Fill under backpressure, then release and drain through the address wrap.
        reset_cycle();
        clear_ch();
        tx_full = 1'b1;
        en = 4'b0001;
        for (int k = 0; k < 10; k++) push_word(0, $urandom);
        repeat (8) cycle();
        check("fill_count", bl.WORD_COUNT, DEPTH);
        check("fill_full", bl.FIFO_FULL, 1);
        check("fill_left", ch_tail[0] - ch_head[0], 6);
        got_l.delete();
        tx_full = 1'b0;
        repeat (50) cycle();
        check("fill_nbytes", got_l.size(), 40);

        // Push landing on the retire edge keeps the count steady.
        reset_cycle();
        clear_ch();
        tx_full = 1'b1;
        push_word(0, $urandom);
        push_word(0, $urandom);
        repeat (3) cycle();
        check("pr_start", bl.WORD_COUNT, 2);
        tx_full = 1'b0;
        for (int n = 0; n < 20; n++) begin
            repeat (3) cycle();
            push_word(0, $urandom);
            cycle();
            check("pr_count", bl.WORD_COUNT, 2);
        end
        repeat (12) cycle();

        // Reset after two bytes of a word.
        reset_cycle();
        clear_ch();
        push_word(0, 32'hDEAD_BEEF);
        push_word(0, 32'hCAFE_F00D);
        repeat (3) cycle();
        got_l.delete();
        reset_cycle();
        repeat (3) cycle();
        check("midrst_silent", got_l.size(), 0);
        w = 32'h5566_7788;
        push_word(0, w);
        repeat (6) cycle();
        check("midrst_nbytes", got_l.size(), 4);
        if (got_l.size() == 4) check("midrst_b0", got_l[0], w[7:0]);

        // Random traffic, masks, backpressure and occasional reset.
        reset_cycle();
        clear_ch();
        for (int n = 0; n < 600; n++) begin
            if (n % 16 == 0) en = 4'($urandom_range(0, 15));
            tx_full = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1) == 1) push_word($urandom_range(0, CH-1), $urandom);
            cycle();
        end
        rst = 1'b0; tx_full = 1'b0; en = '0;
        repeat (40) cycle();
        check("rand_drained", bl.FIFO_EMPTY, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
